usb_rx_bit_decoder: RTL and testbench
=====================================

# usb_rx_bit_decoder

Receive bit-level decoder that consumes the oversampled, clock-recovered line-state symbols produced by the USB wire-data reader and turns them into a byte stream for the packet-level receiver. It handles NRZI decoding, SYNC detection, bit-unstuffing, byte assembly and EOP detection. Every byte is tagged with a control code. It sits between the wire reader's 4-entry symbol FIFO and the SIE packet receiver.

## Interface
- `FS_J`, default 2'b10: full-speed J symbol. K is its inverse. At low speed, J and K swap.
- `SYNC_MIN_ZEROS`, default 5: minimum decoded-0 run that must precede the terminating K-K of SYNC.
- `clk  in  1`: system clock.
- `rst  in  1`: reset. Synchronous, active-high.
- `fullSpeedRate  in  1`: 1 selects full-speed J/K mapping; 0 selects low-speed mapping.
- `rxBitsIn  in  2`: line symbol. 2'b00 is SE0. 2'b11 (SE1) is treated as SE0.
- `rxWireActive  in  1`: qualifier delivered with the symbol.
- `rxWEn  in  1`: upstream symbol-write strobe, one cycle per symbol.
- `rxRdy  out  1`: symbol accept ready. Combinational `!rxByteValid`.
- `rxByteValid  out  1`: output byte valid.
- `rxByteRdy  in  1`: downstream accepts the byte.
- `rxData  out  8`: assembled byte, LSB received first.
- `rxCtrl  out  2`: control code for the byte: START, STREAM, STOP, STUFF_ERR.
- `rxOverrun  out  1`: one-cycle pulse when `rxWEn` arrives while `rxRdy`=0.

## Operation
- **Symbol accept:** a symbol is accepted when `rxWEn && rxRdy`.
  - If `rxWEn && !rxRdy`, the symbol is dropped, `rxOverrun` pulses, and the state is unchanged.
  - Accepted symbols with `rxWireActive`=0 are discarded. If the state is not IDLE, the block returns to IDLE with no output.
- **NRZI decode:** decoded bit = 1 if symbol equals `prevSym`, else 0. `prevSym` is loaded with J on entry to IDLE.
- **States:**
  - IDLE: a K symbol sets `zeroCnt`=1 and moves to SYNC_HUNT. Otherwise stay.
  - SYNC_HUNT:
    - Decoded 0 increments `zeroCnt`, saturating at 7.
    - Decoded 1 on K with `zeroCnt` >= `SYNC_MIN_ZEROS` emits START (`rxData`=0x00), sets `oneCnt`=1 and `bitCnt`=0, and moves to DATA.
    - Any other decoded 1 returns to IDLE.
    - SE0 returns to IDLE.
  - DATA:
    - SE0 emits STOP with `rxData`={5'b0,`bitCnt`}. A nonzero value is a residual-bit framing error. Then move to WAIT_J.
    - When `oneCnt`==6: a decoded 0 is a stuffed bit and is discarded, with `oneCnt`=0. A decoded 1 emits STUFF_ERR (`rxData`=0x00) and moves to WAIT_EOP.
    - Otherwise the bit shifts into `shiftReg[7]` (right shift). `oneCnt` increments on 1 and clears on 0. `bitCnt` increments. When `bitCnt` wraps 7→0, emit STREAM with the shift-register content.
  - WAIT_EOP: discard symbols until SE0, then move to WAIT_J.
  - WAIT_J: a J symbol moves to IDLE. Other symbols are discarded.
- **Emit:** load `rxData`/`rxCtrl` and set `rxByteValid`. It is held until `rxByteRdy`, and cleared in the cycle after `rxByteValid && rxByteRdy`.
- **Reset mid-packet:** all state is abandoned. There is no STOP emission.

## Timing
- Reset values:
  - `rxByteValid`=0, `rxData`=0x00, `rxCtrl`=STREAM, `rxOverrun`=0.
  - `rxRdy`=1.
  - State IDLE, `prevSym`=J, all counters 0.
- Latency: a symbol accepted at edge N that completes a byte gives `rxByteValid`=1 after edge N. `rxRdy` falls in the same cycle.
- Throughput: one symbol per cycle when no byte is pending.
- A byte is handed over on `rxByteValid && rxByteRdy` at a clock edge. In the following cycle `rxByteValid`=0 and `rxRdy`=1.
- Simultaneous accept and handover is impossible, because `rxRdy` is low while a byte is valid.
- The `fullSpeedRate` change takes effect on the next accepted symbol. A change is legal only in IDLE.

## Structure
- Shared package `usb_rx_pkg`:
  - Symbol codes: SE0, ONE_ZERO, ZERO_ONE.
  - rxCtrl codes: START=2'd0, STREAM=2'd1, STOP=2'd2, STUFF_ERR=2'd3.
  - State enum: IDLE, SYNC_HUNT, DATA, WAIT_EOP, WAIT_J.
- Sub-module `usb_rx_unstuff`: `oneCnt`, stuffed-bit discard, shift register and `bitCnt`. It takes a decoded bit plus strobe and returns a byte-done, stuff-error and residual count. The FSM, NRZI decode and output register stay in the top level.

## Test plan
- **Full-speed byte:** SYNC KJKJKJKK, then symbols encoding 0xA5, then SE0,SE0,J → START/0x00, STREAM/0xA5, STOP/0x00, then the block returns to IDLE.
- **Stuffing:** SYNC plus data 0xFF, 0x00 with a stuffed 0 after the 5th data bit → STREAM/0xFF, STREAM/0x00 and no error. Omitting the stuffed bit (seven identical symbols) → STUFF_ERR, and following symbols are ignored until SE0 then J.
- **Low speed:** `fullSpeedRate`=0 with J=2'b01, same 0xA5 packet → identical output sequence.
- **Backpressure:** hold `rxByteRdy`=0 for 10 cycles after a STREAM.
  - `rxRdy` must stay 0 and the byte must stay stable.
  - A forced `rxWEn` in that window → `rxOverrun` one-cycle pulse, and the symbol has no effect.
- **Framing and qualifier:**
  - SE0 after 3 data bits → STOP with `rxData`=0x03.
  - `rxWireActive`=0 mid-packet → return to IDLE with no output.
  - A short SYNC (KJKK) → no START.
- **Reset mid-packet:** assert `rst` after START → `rxByteValid`=0 and `rxRdy`=1. A fresh packet then decodes correctly.

Source files
------------

// File: rtl/usb_rx_bit_decoder_pkg.sv
// Shared constants for the USB receive bit decoder: line symbols, byte control
// codes and FSM state encodings.
package usb_rx_pkg;

    localparam logic [1:0] SYM_SE0      = 2'b00;
    localparam logic [1:0] SYM_ONE_ZERO = 2'b10;
    localparam logic [1:0] SYM_ZERO_ONE = 2'b01;

    localparam logic [1:0] CTRL_START     = 2'd0;
    localparam logic [1:0] CTRL_STREAM    = 2'd1;
    localparam logic [1:0] CTRL_STOP      = 2'd2;
    localparam logic [1:0] CTRL_STUFF_ERR = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SYNC_HUNT = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_WAIT_EOP  = 3'd3;
    localparam logic [2:0] ST_WAIT_J    = 3'd4;

    // A run of six decoded ones means the next bit must be a stuffed zero.
    localparam logic [2:0] STUFF_RUN = 3'd6;

    // SE1 (both lines high) is folded into SE0.
    function automatic logic sym_is_se0(input logic [1:0] sym);
        return sym[1] == sym[0];
    endfunction

endpackage

// File: rtl/usb_rx_bit_decoder_unstuff.sv
// Bit unstuffer and byte assembler: drops stuffed zeros, flags stuff errors
// and shifts data bits LSB-first into a byte.
module usb_rx_unstuff
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init_i,
    input  logic       bit_strobe_i,
    input  logic       bit_i,
    output logic       byte_done_o,
    output logic       stuff_err_o,
    output logic [7:0] byte_o,
    output logic [2:0] bit_cnt_o
);

    logic [2:0] one_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       stuff_slot;

    assign stuff_slot  = (one_cnt_q == STUFF_RUN);
    assign shift_d     = {bit_i, shift_q[7:1]};
    assign stuff_err_o = bit_strobe_i && stuff_slot && bit_i;
    assign byte_done_o = bit_strobe_i && !stuff_slot && (bit_cnt_q == 3'd7);
    assign byte_o      = shift_d;
    assign bit_cnt_o   = bit_cnt_q;

    // init_i seeds the ones run with the final K-K of SYNC, which is a decoded 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            one_cnt_q <= 3'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else if (init_i) begin
            one_cnt_q <= 3'd1;
            bit_cnt_q <= 3'd0;
        end else if (bit_strobe_i) begin
            if (stuff_slot) begin
                if (!bit_i) begin
                    one_cnt_q <= 3'd0;
                end
            end else begin
                shift_q   <= shift_d;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                one_cnt_q <= bit_i ? one_cnt_q + 3'd1 : 3'd0;
            end
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: NRZI decode, SYNC hunt, EOP detection and a single
// output byte register tagged with a control code.
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter logic [1:0] FS_J           = SYM_ONE_ZERO,
    parameter int         SYNC_MIN_ZEROS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fullSpeedRate,
    input  logic [1:0] rxBitsIn,
    input  logic       rxWireActive,
    input  logic       rxWEn,
    output logic       rxRdy,
    output logic       rxByteValid,
    input  logic       rxByteRdy,
    output logic [7:0] rxData,
    output logic [1:0] rxCtrl,
    output logic       rxOverrun,
    output logic [2:0] dbgState
);

    localparam logic [2:0] MIN_ZEROS = 3'(SYNC_MIN_ZEROS);

    logic [2:0] state_q, state_d;
    logic [1:0] prev_sym_q, prev_sym_d;
    logic [2:0] zero_cnt_q, zero_cnt_d;
    logic       valid_q;
    logic [7:0] data_q;
    logic [1:0] ctrl_q;
    logic       overrun_q;

    logic [1:0] j_sym;
    logic [1:0] k_sym;
    logic       accept;
    logic       is_se0;
    logic       dec_bit;

    logic       emit;
    logic [1:0] emit_ctrl;
    logic [7:0] emit_data;
    logic       us_init;
    logic       us_strobe;
    logic       us_byte_done;
    logic       us_stuff_err;
    logic [7:0] us_byte;
    logic [2:0] us_bit_cnt;

    // Low speed swaps the J/K polarity.
    assign j_sym   = fullSpeedRate ? FS_J : ~FS_J;
    assign k_sym   = ~j_sym;
    assign is_se0  = sym_is_se0(rxBitsIn);
    assign dec_bit = (rxBitsIn == prev_sym_q);

    // Handshake: upstream symbols are taken on rxWEn && rxRdy, and rxRdy is low
    // whenever a byte is held; downstream takes the byte on rxByteValid && rxByteRdy.
    assign rxRdy  = !valid_q;
    assign accept = rxWEn && rxRdy;

    usb_rx_unstuff u_unstuff (
        .clk          (clk),
        .rst          (rst),
        .init_i       (us_init),
        .bit_strobe_i (us_strobe),
        .bit_i        (dec_bit),
        .byte_done_o  (us_byte_done),
        .stuff_err_o  (us_stuff_err),
        .byte_o       (us_byte),
        .bit_cnt_o    (us_bit_cnt)
    );

    always_comb begin
        state_d    = state_q;
        zero_cnt_d = zero_cnt_q;
        prev_sym_d = prev_sym_q;
        emit       = 1'b0;
        emit_ctrl  = CTRL_STREAM;
        emit_data  = 8'h00;
        us_init    = 1'b0;
        us_strobe  = 1'b0;
        if (accept) begin
            if (!rxWireActive) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rxBitsIn == k_sym) begin
                            zero_cnt_d = 3'd1;
                            state_d    = ST_SYNC_HUNT;
                        end
                    end
                    ST_SYNC_HUNT: begin
                        if (is_se0) begin
                            state_d = ST_IDLE;
                        end else if (!dec_bit) begin
                            if (zero_cnt_q != 3'd7) begin
                                zero_cnt_d = zero_cnt_q + 3'd1;
                            end
                        end else if ((rxBitsIn == k_sym) && (zero_cnt_q >= MIN_ZEROS)) begin
                            emit      = 1'b1;
                            emit_ctrl = CTRL_START;
                            us_init   = 1'b1;
                            state_d   = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (is_se0) begin
                            emit      = 1'b1;
                            emit_ctrl = CTRL_STOP;
                            emit_data = {5'b0, us_bit_cnt};
                            state_d   = ST_WAIT_J;
                        end else begin
                            us_strobe = 1'b1;
                            if (us_stuff_err) begin
                                emit      = 1'b1;
                                emit_ctrl = CTRL_STUFF_ERR;
                                state_d   = ST_WAIT_EOP;
                            end else if (us_byte_done) begin
                                emit      = 1'b1;
                                emit_ctrl = CTRL_STREAM;
                                emit_data = us_byte;
                            end
                        end
                    end
                    ST_WAIT_EOP: begin
                        if (is_se0) begin
                            state_d = ST_WAIT_J;
                        end
                    end
                    ST_WAIT_J: begin
                        if (rxBitsIn == j_sym) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            prev_sym_d = (state_d == ST_IDLE) ? j_sym : rxBitsIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prev_sym_q <= j_sym;
            zero_cnt_q <= 3'd0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= CTRL_STREAM;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_sym_q <= prev_sym_d;
            zero_cnt_q <= zero_cnt_d;
            overrun_q  <= rxWEn && !rxRdy;
            if (emit) begin
                valid_q <= 1'b1;
                data_q  <= emit_data;
                ctrl_q  <= emit_ctrl;
            end else if (valid_q && rxByteRdy) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rxByteValid = valid_q;
    assign rxData      = data_q;
    assign rxCtrl      = ctrl_q;
    assign rxOverrun   = overrun_q;
    assign dbgState    = state_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: NRZI-encodes packets onto the symbol
// port and scores every handed-over byte against an expected queue.
module tb_usb_rx_bit_decoder;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       fullSpeedRate;
    logic [1:0] rxBitsIn;
    logic       rxWireActive;
    logic       rxWEn;
    logic       rxRdy;
    logic       rxByteValid;
    logic       rxByteRdy;
    logic [7:0] rxData;
    logic [1:0] rxCtrl;
    logic       rxOverrun;
    logic [2:0] dbgState;

    int tests  = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [1:0] level;

    usb_rx_bit_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .fullSpeedRate (fullSpeedRate),
        .rxBitsIn      (rxBitsIn),
        .rxWireActive  (rxWireActive),
        .rxWEn         (rxWEn),
        .rxRdy         (rxRdy),
        .rxByteValid   (rxByteValid),
        .rxByteRdy     (rxByteRdy),
        .rxData        (rxData),
        .rxCtrl        (rxCtrl),
        .rxOverrun     (rxOverrun),
        .dbgState      (dbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a byte is handed over at the next posedge when valid && rdy here.
    always @(negedge clk) begin
        if (!rst && rxByteValid && rxByteRdy) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("byte", 32'({rxCtrl, rxData}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [1:0] jsym();
        return fullSpeedRate ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] ksym();
        return fullSpeedRate ? 2'b01 : 2'b10;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sym(input logic [1:0] s, input logic act);
        int budget;
        budget = 0;
        while (!rxRdy && budget < 100) begin
            tick(1);
            budget++;
        end
        if (!rxRdy) check("rxRdy_timeout", 32'(rxRdy), 32'd1);
        rxBitsIn     = s;
        rxWireActive = act;
        rxWEn        = 1'b1;
        tick(1);
        rxWEn        = 1'b0;
        rxWireActive = 1'b1;
    endtask

    // NRZI: a 0 toggles the line, a 1 repeats it.
    task automatic send_bit(input logic b);
        if (!b) level = (level == jsym()) ? ksym() : jsym();
        send_sym(level, 1'b1);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    // KJKJKJKK
    task automatic send_sync();
        level = ksym();
        send_sym(level, 1'b1);
        send_bits(8'b0100_0000, 7);
    endtask

    task automatic send_eop();
        send_sym(SYM_SE0, 1'b1);
        send_sym(SYM_SE0, 1'b1);
        send_sym(jsym(), 1'b1);
    endtask

    task automatic push(input logic [1:0] ctrl, input logic [7:0] data);
        exp_q.push_back({ctrl, data});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        fullSpeedRate = 1'b1;
        rxBitsIn      = SYM_SE0;
        rxWireActive  = 1'b1;
        rxWEn         = 1'b0;
        rxByteRdy     = 1'b1;
        level         = 2'b10;
        tick(3);
        check("rst_valid", 32'(rxByteValid), 32'd0);
        check("rst_data", 32'(rxData), 32'h00);
        check("rst_ctrl", 32'(rxCtrl), 32'(CTRL_STREAM));
        check("rst_overrun", 32'(rxOverrun), 32'd0);
        check("rst_rdy", 32'(rxRdy), 32'd1);
        check("rst_state", 32'(dbgState), 32'(ST_IDLE));
        rst = 1'b0;
        tick(2);

        // Full-speed 0xA5 packet
        push(CTRL_START, 8'h00);
        push(CTRL_STREAM, 8'hA5);
        push(CTRL_STOP, 8'h00);
        send_sync();
        send_bits(8'hA5, 8);
        send_eop();
        tick(2);
        check("fs_back_to_idle", 32'(dbgState), 32'(ST_IDLE));

        // Stuffed zero after five data ones, then 0x00
        push(CTRL_START, 8'h00);
        push(CTRL_STREAM, 8'hFF);
        push(CTRL_STREAM, 8'h00);
        push(CTRL_STOP, 8'h00);
        send_sync();
        send_bits(8'h1F, 5);
        send_bit(1'b0);
        send_bits(8'h07, 3);
        send_bits(8'h00, 8);
        send_eop();
        tick(2);
        check("stuff_back_to_idle", 32'(dbgState), 32'(ST_IDLE));

        // Missing stuffed bit -> STUFF_ERR, then ignore until SE0 and J
        push(CTRL_START, 8'h00);
        push(CTRL_STUFF_ERR, 8'h00);
        send_sync();
        send_bits(8'h3F, 6);
        tick(2);
        check("stuff_err_wait_eop", 32'(dbgState), 32'(ST_WAIT_EOP));
        send_sym(jsym(), 1'b1);
        send_sym(ksym(), 1'b1);
        send_sym(jsym(), 1'b1);
        check("wait_eop_ignores", 32'(dbgState), 32'(ST_WAIT_EOP));
        send_sym(SYM_SE0, 1'b1);
        check("eop_to_wait_j", 32'(dbgState), 32'(ST_WAIT_J));
        send_sym(ksym(), 1'b1);
        check("wait_j_ignores_k", 32'(dbgState), 32'(ST_WAIT_J));
        send_sym(jsym(), 1'b1);
        check("wait_j_to_idle", 32'(dbgState), 32'(ST_IDLE));

        // Low-speed 0xA5 packet
        fullSpeedRate = 1'b0;
        push(CTRL_START, 8'h00);
        push(CTRL_STREAM, 8'hA5);
        push(CTRL_STOP, 8'h00);
        send_sync();
        send_bits(8'hA5, 8);
        send_eop();
        tick(2);
        check("ls_back_to_idle", 32'(dbgState), 32'(ST_IDLE));
        fullSpeedRate = 1'b1;
        tick(1);

        // Backpressure with a forced write during the hold window
        push(CTRL_START, 8'h00);
        push(CTRL_STREAM, 8'hA5);
        push(CTRL_STOP, 8'h00);
        send_sync();
        send_bits(8'hA5, 7);
        rxByteRdy = 1'b0;
        send_bit(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                rxBitsIn = SYM_SE0;
                rxWEn    = 1'b1;
            end
            tick(1);
            rxWEn = 1'b0;
            check("bp_rdy_low", 32'(rxRdy), 32'd0);
            check("bp_data_stable", 32'({rxByteValid, rxCtrl, rxData}), 32'({1'b1, CTRL_STREAM, 8'hA5}));
            check("bp_overrun", 32'(rxOverrun), 32'(i == 4));
        end
        check("bp_state_unchanged", 32'(dbgState), 32'(ST_DATA));
        rxByteRdy = 1'b1;
        tick(1);
        send_eop();
        tick(2);

        // SE0 after three data bits -> residual count 3
        push(CTRL_START, 8'h00);
        push(CTRL_STOP, 8'h03);
        send_sync();
        send_bits(8'h05, 3);
        send_eop();
        tick(2);

        // Qualifier drop mid-packet -> silent return to IDLE
        push(CTRL_START, 8'h00);
        send_sync();
        send_bits(8'h0F, 4);
        send_sym(level, 1'b0);
        check("inactive_to_idle", 32'(dbgState), 32'(ST_IDLE));
        tick(3);

        // Short SYNC KJKK -> no START
        send_sym(ksym(), 1'b1);
        send_sym(jsym(), 1'b1);
        send_sym(ksym(), 1'b1);
        send_sym(ksym(), 1'b1);
        check("short_sync_idle", 32'(dbgState), 32'(ST_IDLE));
        send_sym(jsym(), 1'b1);
        tick(3);

        // Reset while START is held, then a fresh packet
        rxByteRdy = 1'b0;
        send_sync();
        check("start_held", 32'({rxByteValid, rxCtrl, rxData}), 32'({1'b1, CTRL_START, 8'h00}));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_valid", 32'(rxByteValid), 32'd0);
        check("mid_rst_rdy", 32'(rxRdy), 32'd1);
        check("mid_rst_state", 32'(dbgState), 32'(ST_IDLE));
        rxByteRdy = 1'b1;
        tick(1);
        push(CTRL_START, 8'h00);
        push(CTRL_STREAM, 8'h3C);
        push(CTRL_STOP, 8'h00);
        send_sync();
        send_bits(8'h3C, 8);
        send_eop();
        tick(5);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
